// File: rtl/id_fsm_param.sv
// ============================================================================
//  Module   : id_fsm_param
//  Purpose  : Letter-run/digit-run identifier recogniser with run and match
//             counters. Optional macro ID_UNDERSCORE_EN classes '_' as LETTER.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module id_fsm_param #(
  parameter int unsigned MIN_ALPHA = 1,
  parameter int unsigned MIN_DIGIT = 1,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             char_valid,
  input  logic [7:0]       char,
  output logic             out,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] alpha_run,
  output logic [CNT_W-1:0] digit_run,
  output logic [CNT_W-1:0] match_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALPHA = 2'd1,
    ST_DIGIT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_max   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_cnt_one   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_cnt_zero  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] c_min_alpha = CNT_W'(MIN_ALPHA);
  localparam logic [CNT_W-1:0] c_min_digit = CNT_W'(MIN_DIGIT);

  state_t           r_state;
  logic [CNT_W-1:0] r_alpha_run;
  logic [CNT_W-1:0] r_digit_run;
  logic [CNT_W-1:0] r_match_cnt;

  state_t           w_state_next;
  logic [CNT_W-1:0] w_alpha_next;
  logic [CNT_W-1:0] w_digit_next;
  logic [CNT_W-1:0] w_match_next;
  logic             w_is_letter;
  logic             w_is_digit;
  logic             w_out_cur;
  logic             w_out_next;

  // Character classification
  always_comb begin
    w_is_letter = ((char >= 8'h61) && (char <= 8'h7A)) ||
                  ((char >= 8'h41) && (char <= 8'h5A));
`ifdef ID_UNDERSCORE_EN
    if (char == 8'h5F) begin
      w_is_letter = 1'b1;
    end
`endif
    w_is_digit = (char >= 8'h30) && (char <= 8'h39);
  end

  // Next-state and run-counter logic
  always_comb begin
    w_state_next = r_state;
    w_alpha_next = r_alpha_run;
    w_digit_next = r_digit_run;
    if (char_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (w_is_letter) begin
            w_state_next = ST_ALPHA;
            w_alpha_next = c_cnt_one;
            w_digit_next = c_cnt_zero;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
        ST_ALPHA: begin
          if (w_is_letter) begin
            w_alpha_next = (r_alpha_run == c_cnt_max) ? r_alpha_run
                                                      : r_alpha_run + c_cnt_one;
          end else if (w_is_digit) begin
            w_state_next = ST_DIGIT;
            w_digit_next = c_cnt_one;
          end else begin
            w_state_next = ST_IDLE;
            w_alpha_next = c_cnt_zero;
            w_digit_next = c_cnt_zero;
          end
        end
        ST_DIGIT: begin
          if (w_is_digit) begin
            w_digit_next = (r_digit_run == c_cnt_max) ? r_digit_run
                                                      : r_digit_run + c_cnt_one;
          end else if (w_is_letter) begin
            w_state_next = ST_ALPHA;
            w_alpha_next = c_cnt_one;
            w_digit_next = c_cnt_zero;
          end else begin
            w_state_next = ST_IDLE;
            w_alpha_next = c_cnt_zero;
            w_digit_next = c_cnt_zero;
          end
        end
        default: begin
          w_state_next = ST_IDLE;
          w_alpha_next = c_cnt_zero;
          w_digit_next = c_cnt_zero;
        end
      endcase
    end
  end

  // A new token always enters ALPHA (unmatched) first, so a rising edge of
  // the match condition marks exactly one matched token.
  always_comb begin
    w_out_cur  = (r_state == ST_DIGIT) && (r_alpha_run >= c_min_alpha) &&
                 (r_digit_run >= c_min_digit);
    w_out_next = (w_state_next == ST_DIGIT) && (w_alpha_next >= c_min_alpha) &&
                 (w_digit_next >= c_min_digit);
    w_match_next = r_match_cnt;
    if (char_valid && w_out_next && !w_out_cur && (r_match_cnt != c_cnt_max)) begin
      w_match_next = r_match_cnt + c_cnt_one;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_alpha_run <= c_cnt_zero;
      r_digit_run <= c_cnt_zero;
      r_match_cnt <= c_cnt_zero;
    end else begin
      r_state     <= w_state_next;
      r_alpha_run <= w_alpha_next;
      r_digit_run <= w_digit_next;
      r_match_cnt <= w_match_next;
    end
  end

  assign out       = w_out_cur;
  assign state     = r_state;
  assign alpha_run = r_alpha_run;
  assign digit_run = r_digit_run;
  assign match_cnt = r_match_cnt;

endmodule

`default_nettype wire

// File: tb/tb_id_fsm_param.sv
// ============================================================================
//  Module   : tb_id_fsm_param
//  Purpose  : Directed self-checking bench for id_fsm_param (three configs).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_id_fsm_param;

  logic       clk;
  logic       rst_n;
  logic       char_valid;
  logic [7:0] char;

  logic       def_out,   p23_out,   w3_out;
  logic [1:0] def_state, p23_state, w3_state;
  logic [7:0] def_alpha, def_digit, def_match;
  logic [7:0] p23_alpha, p23_digit, p23_match;
  logic [2:0] w3_alpha,  w3_digit,  w3_match;

  int n_checks;
  int n_fail;

  id_fsm_param u_def (
    .clk(clk), .rst_n(rst_n), .char_valid(char_valid), .char(char),
    .out(def_out), .state(def_state), .alpha_run(def_alpha),
    .digit_run(def_digit), .match_cnt(def_match)
  );

  id_fsm_param #(.MIN_ALPHA(2), .MIN_DIGIT(3), .CNT_W(8)) u_p23 (
    .clk(clk), .rst_n(rst_n), .char_valid(char_valid), .char(char),
    .out(p23_out), .state(p23_state), .alpha_run(p23_alpha),
    .digit_run(p23_digit), .match_cnt(p23_match)
  );

  id_fsm_param #(.MIN_ALPHA(1), .MIN_DIGIT(1), .CNT_W(3)) u_w3 (
    .clk(clk), .rst_n(rst_n), .char_valid(char_valid), .char(char),
    .out(w3_out), .state(w3_state), .alpha_run(w3_alpha),
    .digit_run(w3_digit), .match_cnt(w3_match)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] c);
    char       = c;
    char_valid = 1'b1;
    @(posedge clk);
    #1;
    char_valid = 1'b0;
  endtask

  task automatic do_reset();
    char_valid = 1'b0;
    rst_n      = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Drive a string and compare the default instance's out after each char
  task automatic run_def(input string s, input string exp_out);
    for (int i = 0; i < s.len(); i++) begin
      send(s[i]);
      check($sformatf("def_out[%0d]", i), 32'(def_out), 32'(exp_out[i] == "1"));
    end
  endtask

  task automatic run_p23(input string s, input string exp_out);
    for (int i = 0; i < s.len(); i++) begin
      send(s[i]);
      check($sformatf("p23_out[%0d]", i), 32'(p23_out), 32'(exp_out[i] == "1"));
    end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    char_valid = 1'b0;
    char       = 8'h00;

    // Reset state, before any clock edge
    #1;
    check("rst_out",   32'(def_out),   0);
    check("rst_state", 32'(def_state), 0);
    check("rst_alpha", 32'(def_alpha), 0);
    check("rst_digit", 32'(def_digit), 0);
    check("rst_match", 32'(def_match), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // abcd1234/
    run_def("abcd1234", "00001111");
    check("t1_alpha", 32'(def_alpha), 4);
    check("t1_digit", 32'(def_digit), 4);
    check("t1_state", 32'(def_state), 2);
    run_def("/", "0");
    check("t1_match", 32'(def_match), 1);
    check("t1_idle_alpha", 32'(def_alpha), 0);

    // a22a/2
    do_reset();
    run_def("a22a/2", "011000");
    check("t2_match", 32'(def_match), 1);
    check("t2_state", 32'(def_state), 0);

    // MIN_ALPHA=2, MIN_DIGIT=3
    do_reset();
    run_p23("ab12c123", "00000000");
    check("t3_alpha", 32'(p23_alpha), 1);
    check("t3_match", 32'(p23_match), 0);
    run_p23("abc123", "000001");
    check("t3b_match", 32'(p23_match), 1);
    check("t3b_alpha", 32'(p23_alpha), 3);

    // Gap between x and 1
    do_reset();
    send("x");
    for (int i = 0; i < 5; i++) begin
      char = "1";
      @(posedge clk);
      #1;
      check("gap_state", 32'(def_state), 1);
      check("gap_alpha", 32'(def_alpha), 1);
      check("gap_out",   32'(def_out),   0);
    end
    send("1");
    check("gap_end_out",   32'(def_out),   1);
    check("gap_end_match", 32'(def_match), 1);

    // CNT_W=3 saturation
    do_reset();
    for (int i = 0; i < 10; i++) send("q");
    check("w3_alpha_sat", 32'(w3_alpha), 7);
    check("w3_out_pre",   32'(w3_out),   0);
    send("5");
    check("w3_out",   32'(w3_out),   1);
    check("w3_digit", 32'(w3_digit), 1);
    do_reset();
    for (int i = 0; i < 9; i++) begin
      send("a");
      send("1");
      send(" ");
      if (i == 6) check("w3_match_7", 32'(w3_match), 7);
    end
    check("w3_match_hold", 32'(w3_match), 7);
    check("def_match_9",   32'(def_match), 9);

    // Asynchronous reset mid-match
    do_reset();
    run_def("ab12", "0011");
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out",   32'(def_out),   0);
    check("arst_state", 32'(def_state), 0);
    check("arst_alpha", 32'(def_alpha), 0);
    check("arst_digit", 32'(def_digit), 0);
    check("arst_match", 32'(def_match), 0);
    #2;
    rst_n = 1'b1;

    // Underscore handling
    do_reset();
`ifdef ID_UNDERSCORE_EN
    run_def("_9", "01");
`else
    run_def("_9", "00");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
